// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: shared types and defaults for the register-dump debug path.
package mips_debug_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NREGS_DEF = 32;
    localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / 8;
endpackage

// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: control, register-bank debug port and byte-sink signals of the dump controller.
interface reg_dump_ctrl_if import mips_debug_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
    logic i_start, i_abort, i_tx_ready;
    logic [DATA_WIDTH-1:0] i_reg_data;
    logic [4:0] o_debug_addr;
    logic o_debug, o_freeze, o_tx_valid, o_done, o_busy;
    logic [7:0] o_tx_data;
    modport master (input i_start, i_abort, i_tx_ready, i_reg_data,
                    output o_debug_addr, o_debug, o_freeze, o_tx_valid, o_tx_data, o_done, o_busy);
    modport slave (output i_start, i_abort, i_tx_ready, i_reg_data,
                   input o_debug_addr, o_debug, o_freeze, o_tx_valid, o_tx_data, o_done, o_busy);
endinterface

// File: rtl/word_serializer.sv
// word_serializer: sends a loaded word LSB byte first over a valid/ready byte channel.
module word_serializer import mips_debug_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  send,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic [7:0]            tx_data,
    output logic                  last
);
    localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    logic xfer;
    assign valid = send;
    assign xfer = send && ready;
    // Data is gated so the sink sees zero whenever no byte is offered.
    assign tx_data = send ? sr[7:0] : 8'd0;
    assign last = xfer && cnt == CW'(BPW - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            cnt <= '0;
        end else if (load) begin
            sr <= data;
            cnt <= '0;
        end else if (xfer) begin
            sr <= sr >> 8;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: freezes the pipeline and streams every register-bank entry out as bytes.
module reg_dump_ctrl import mips_debug_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input logic i_clock,
    input logic i_reset,
    reg_dump_ctrl_if.master bus
);
    state_t state, state_nxt;
    logic [4:0] addr, addr_nxt;
    logic word_last, last_reg;
    word_serializer #(.DATA_WIDTH(DATA_WIDTH), .BPW(DATA_WIDTH / 8)) u_ser (
        .clk(i_clock),
        .rst(i_reset),
        .load(state == LOAD),
        .send(state == SEND),
        .ready(bus.i_tx_ready),
        .data(bus.i_reg_data),
        .valid(bus.o_tx_valid),
        .tx_data(bus.o_tx_data),
        .last(word_last)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            addr <= '0;
        end else begin
            state <= state_nxt;
            addr <= addr_nxt;
        end
    end
    always_comb begin
        last_reg = addr == 5'(NREGS - 1);
        state_nxt = state;
        case (state)
            IDLE: state_nxt = bus.i_start ? LOAD : IDLE;
            LOAD: state_nxt = SEND;
            SEND: state_nxt = !word_last ? SEND : last_reg ? DONE : LOAD;
            default: state_nxt = IDLE;
        endcase
        if (bus.i_abort && state != IDLE) state_nxt = IDLE;
        // Address only advances between words; leaving the dump returns it to 0.
        addr_nxt = (state == SEND && state_nxt == LOAD) ? addr + 5'd1 :
                   (state_nxt == LOAD || state_nxt == SEND) ? addr : 5'd0;
    end
    assign bus.o_debug_addr = addr;
    assign bus.o_busy = state != IDLE;
    assign bus.o_debug = state != IDLE;
    assign bus.o_freeze = state != IDLE;
    assign bus.o_done = state == DONE;
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: vector table plus directed dump, backpressure, abort and reset sequences.
module tb_reg_dump_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    reg_dump_ctrl_if #(.DATA_WIDTH(32)) bus ();
    reg_dump_ctrl #(.DATA_WIDTH(32), .NREGS(32)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.i_reg_data = 32'h1000_0000 + {27'd0, bus.o_debug_addr};

    typedef struct packed {
        logic start, abort, ready;
        logic busy, valid;
        logic [7:0] data;
        logic [4:0] addr;
        logic done;
    } vec_t;
    vec_t vecs [13];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs;
        return 32'({bus.o_busy, bus.o_debug, bus.o_freeze, bus.o_tx_valid, bus.o_done,
                    bus.o_debug_addr, bus.o_tx_data});
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_tx_ready = 1'b1;
        repeat (3) step;
        chk("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_for(input logic [4:0] a, input logic v, input string name);
        int n;
        n = 0;
        while (!(bus.o_busy && bus.o_debug_addr == a && bus.o_tx_valid == v) && n < 500) begin
            step;
            n++;
        end
        if (n >= 500) chk({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic full_dump(input int mode, input string tag);
        logic [7:0] bytes [$];
        logic [31:0] w;
        logic hold, pulsed;
        logic [7:0] pd;
        int n, done_cnt, done_n, mism;
        bytes.delete();
        hold = 1'b0;
        pulsed = 1'b0;
        pd = 8'd0;
        done_cnt = 0;
        done_n = 0;
        bus.i_abort = 1'b0;
        bus.i_tx_ready = 1'b1;
        bus.i_start = 1'b1;
        step;
        bus.i_start = 1'b0;
        n = 1;
        while (n < 2000) begin
            if (n == 1) chk({tag, "_busy_t1"}, 32'(bus.o_busy), 32'd1);
            if (bus.o_done) begin
                done_cnt++;
                done_n = n;
            end
            if (!bus.o_busy) break;
            bus.i_tx_ready = (mode == 1) ? (n % 3 == 1) : 1'b1;
            bus.i_start = (mode == 2) && bus.o_debug_addr == 5'd5 && !pulsed;
            if (bus.i_start) pulsed = 1'b1;
            if (hold) chk({tag, "_hold_stable"}, 32'({bus.o_tx_valid, bus.o_tx_data}), 32'({1'b1, pd}));
            if (bus.o_tx_valid && bus.i_tx_ready) bytes.push_back(bus.o_tx_data);
            hold = bus.o_tx_valid && !bus.i_tx_ready;
            pd = bus.o_tx_data;
            step;
            n++;
        end
        bus.i_start = 1'b0;
        bus.i_tx_ready = 1'b1;
        chk({tag, "_terminates"}, 32'(n < 2000), 32'd1);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_byte_count"}, 32'(bytes.size()), 32'd128);
        if (mode == 2) chk({tag, "_restart_pulsed"}, 32'(pulsed), 32'd1);
        if (mode != 1) begin
            chk({tag, "_done_cycle"}, 32'(done_n), 32'd161);
            chk({tag, "_idle_cycle"}, 32'(n), 32'd162);
        end
        if (bytes.size() == 128) begin
            mism = 0;
            for (int i = 0; i < 128; i++) begin
                w = 32'h1000_0000 + 32'(i / 4);
                if (bytes[i] !== w[8*(i%4) +: 8]) mism++;
            end
            chk({tag, "_byte_mismatches"}, 32'(mism), 32'd0);
            chk({tag, "_first4"}, {bytes[0], bytes[1], bytes[2], bytes[3]}, 32'h0000_0010);
            chk({tag, "_last4"}, {bytes[124], bytes[125], bytes[126], bytes[127]}, 32'h1F00_0010);
        end
    endtask

    initial begin
        // start abort ready | busy valid data addr done
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 5'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 5'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 5'd0, 1'b0};

        do_reset;
        for (int i = 0; i < 13; i++) begin
            bus.i_start = vecs[i].start;
            bus.i_abort = vecs[i].abort;
            bus.i_tx_ready = vecs[i].ready;
            step;
            chk($sformatf("vec%0d", i), outs(),
                32'({vecs[i].busy, vecs[i].busy, vecs[i].busy, vecs[i].valid, vecs[i].done,
                     vecs[i].addr, vecs[i].data}));
        end

        do_reset;
        full_dump(0, "dump");
        do_reset;
        full_dump(1, "backpressure");
        do_reset;
        full_dump(2, "restart_ignored");

        // Abort during reg 10, byte 2.
        do_reset;
        bus.i_start = 1'b1;
        step;
        bus.i_start = 1'b0;
        wait_for(5'd10, 1'b1, "abort_wait");
        chk("abort_reg10_byte0", 32'(bus.o_tx_data), 32'h0A);
        step;
        step;
        bus.i_abort = 1'b1;
        step;
        bus.i_abort = 1'b0;
        chk("abort_outputs", outs(), 32'd0);
        repeat (3) begin
            step;
            chk("abort_no_done", 32'({bus.o_done, bus.o_busy}), 32'd0);
        end
        bus.i_start = 1'b1;
        step;
        bus.i_start = 1'b0;
        chk("abort_restart_load", outs(), 32'h38000);
        step;
        chk("abort_restart_send", 32'({bus.o_tx_valid, bus.o_debug_addr, bus.o_tx_data}), 32'h2000);

        // Reset during LOAD of reg 20, then restart right after release.
        do_reset;
        bus.i_start = 1'b1;
        step;
        bus.i_start = 1'b0;
        wait_for(5'd20, 1'b0, "reset_wait");
        rst = 1'b1;
        step;
        chk("midreset_outputs", outs(), 32'd0);
        rst = 1'b0;
        full_dump(0, "post_reset");

        // Abort coinciding with the final byte transfer.
        do_reset;
        bus.i_start = 1'b1;
        step;
        bus.i_start = 1'b0;
        wait_for(5'd31, 1'b1, "final_wait");
        step;
        step;
        step;
        chk("final_byte_data", 32'({bus.o_tx_valid, bus.o_tx_data}), 32'h110);
        bus.i_abort = 1'b1;
        step;
        bus.i_abort = 1'b0;
        chk("final_abort_outputs", outs(), 32'd0);
        step;
        chk("final_abort_no_done", 32'({bus.o_done, bus.o_busy}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
